dcache: RTL and testbench
=========================

Name: dcache

Overview:
- Data-cache responder for the load-store queue's dcache request interface. Accepts one load or store per handshake and returns load data tagged with the LSQ id.
- Organisation: direct-mapped, write-through, no-write-allocate, blocking (at most one outstanding miss).
- Sits between the LSQ and the memory bus. Misses fill a whole line over a burst read port. Stores go straight to memory as single masked writes.

Parameters:
SETS, 64, number of lines (power of two)
LINE_WORDS, 4, 32-bit words per line (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
lsq_dc_req  in  1  request valid
lsq_dc_op  in  4  {funct3[2:0], is_store}
lsq_dc_addr  in  32  byte address
lsq_dc_lsqid  in  4  load tag, echoed on response
lsq_dc_wdata  in  32  store data, right-aligned
lsq_dc_flush  in  1  pipeline flush
dcache_ready  out  1  request accepted this cycle when high with lsq_dc_req
dcache_valid  out  1  one-cycle load response pulse
dcache_error  out  1  response is a fault (misaligned or illegal funct3)
dcache_lsqid  out  4  tag of response
dcache_rdata  out  32  extended load data
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = line read
mem_addr  out  32  write: word address; read: line-aligned address
mem_wdata  out  32  write data, byte-lane aligned
mem_wmask  out  4  byte enables
mem_ready  in  1  memory accepts request
mem_rvalid  in  1  fill beat valid, beats arrive in ascending word order
mem_rdata  in  32  fill beat data

Behaviour:
- Address split: offset = log2(LINE_WORDS)+2 bits; index = log2(SETS) bits; tag = remaining bits.
- Per-line state: valid bit, tag, data.
- Reset (async): all line valid bits = 0; state = IDLE; kill = 0; beat count = 0; every output = 0.
- States:
  - IDLE: dcache_ready = 1.
  - STORE: drive the memory write.
  - FILL_REQ: drive the line read.
  - FILL: count incoming beats.
  - RESP: emit the miss response.
  - dcache_ready = 0 in every state other than IDLE.
- Beat: lsq_dc_req & dcache_ready & ~lsq_dc_flush. When flush is high, a request in the same cycle is ignored and not accepted.
- Load, funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other encoding is illegal.
  - Misaligned or illegal: dcache_valid = 1 next cycle, dcache_error = 1, rdata = 0. No memory access; stay in IDLE.
  - Hit: dcache_valid next cycle with extracted data; stay in IDLE. Back-to-back hits give one response per cycle.
  - Miss: latch tag, index, offset, lsqid and op; go to FILL_REQ.
- FILL_REQ: mem_req = 1, mem_we = 0, addr = line base. When mem_ready, go to FILL with beat count = 0.
- FILL: on each mem_rvalid, write the beat into the data array at beat count, then count+1.
  - On beat LINE_WORDS-1: set the line valid and write the tag, then go to RESP.
- RESP: dcache_valid = ~kill, carrying the latched lsqid and data extracted from the filled line. Clear kill; go to IDLE.
- Data extraction: select byte/halfword by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Store (SB 000, SH 001, SW 010):
  - Misaligned or illegal: dropped with no memory write. Store stays in IDLE and never produces a response.
  - Otherwise: go to STORE with mem_req = 1, mem_we = 1, addr[1:0] = 0. wdata is replicated into lanes: byte x4, half x2.
  - wmask per size: SB = 1<<addr[1:0]; SH = 0011 or 1100; SW = 1111.
  - On a hit, the cached word is updated under the mask in the accept cycle.
  - Return to IDLE on mem_ready.
- Flush:
  - Stores are never cancelled; STORE always completes.
  - Flush in FILL_REQ or FILL, or in the same cycle as a miss beat: set kill. The fill still completes and installs the line. RESP then emits no dcache_valid.
  - Flush in RESP suppresses that cycle's dcache_valid.
  - Flush in IDLE when a hit or error response is due next cycle: that response is suppressed.
- No store-to-load forwarding; LSQ ordering guarantees correctness.
- Reset mid-fill: state returns to IDLE and all lines are invalid. Memory must also be reset, so any further beats are ignored.

Test Plan:
- Cold LW 0x100 (lsqid 3), mem line = {11,22,33,44}: mem read at 0x100; dcache_valid 1 cycle after 4th beat, rdata = 0x11, lsqid = 3; repeat LW 0x104 -> hit, valid next cycle, rdata = 0x22.
- Line holding 0x80FF7F01 at 0x100: LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x80; LH 0x102 -> 0xFFFF80FF; LHU 0x100 -> 0x7F01.
- SB 0x101 data 0xAB after line resident: mem write addr 0x100, wdata 0xABABABAB, wmask 0010; ready low until mem_ready; next LW 0x100 returns the byte merged.
- LW 0x102 -> dcache_error = 1 next cycle, no mem_req; SH 0x103 -> no mem_req, no response, ready stays 1.
- Miss on LW 0x200, flush asserted during beat 2: no dcache_valid; later LW 0x200 hits without mem_req.
- Hit requests at consecutive cycles with lsqids 1, 2, 3: responses in consecutive cycles in order; flush with req high -> request not accepted, no response.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate blocking data cache for the LSQ.
// Hits and faults answer the cycle after acceptance; misses fill a whole line by burst read.
module dcache #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsq_dc_req,
  input  logic [3:0]  lsq_dc_op,
  input  logic [31:0] lsq_dc_addr,
  input  logic [3:0]  lsq_dc_lsqid,
  input  logic [31:0] lsq_dc_wdata,
  input  logic        lsq_dc_flush,
  output logic        dcache_ready,
  output logic        dcache_valid,
  output logic        dcache_error,
  output logic [3:0]  dcache_lsqid,
  output logic [31:0] dcache_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, STORE, FILL_REQ, FILL, RESP} state_t;
  state_t state_q, state_d;

  logic [SETS-1:0]   vld_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS][LINE_WORDS];

  logic              kill_q;
  logic [WOFF_W-1:0] cnt_q;
  logic [31:0]       lat_addr;
  logic [2:0]        lat_op;
  logic [3:0]        lat_id;
  logic [31:0]       st_wdata;
  logic [3:0]        st_mask;
  logic              hv_q, he_q;
  logic [31:0]       hd_q;
  logic [3:0]        hid_q;

  logic [2:0]        f3;
  logic              is_st, beat, hit, legal, aligned, ok;
  logic [IDX_W-1:0]  idx, lat_idx;
  logic [TAG_W-1:0]  tag;
  logic [WOFF_W-1:0] woff, lat_woff;
  logic [31:0]       st_lane;
  logic [3:0]        st_mk;
  logic              resp_fill;

  assign f3       = lsq_dc_op[3:1];
  assign is_st    = lsq_dc_op[0];
  assign idx      = lsq_dc_addr[OFF_W +: IDX_W];
  assign tag      = lsq_dc_addr[31 -: TAG_W];
  assign woff     = lsq_dc_addr[2 +: WOFF_W];
  assign lat_idx  = lat_addr[OFF_W +: IDX_W];
  assign lat_woff = lat_addr[2 +: WOFF_W];
  assign hit      = vld_q[idx] & (tag_q[idx] == tag);
  assign beat     = lsq_dc_req & dcache_ready & ~lsq_dc_flush;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f,
                                          input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    legal   = is_st ? (f3 inside {3'b000, 3'b001, 3'b010})
                    : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    aligned = 1'b1;
    case (f3[1:0])
      2'b01:   aligned = ~lsq_dc_addr[0];
      2'b10:   aligned = (lsq_dc_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    ok = legal & aligned;
  end

  // Narrow stores are replicated across lanes so the mask alone picks the bytes.
  always_comb begin
    st_lane = lsq_dc_wdata;
    st_mk   = 4'hF;
    case (f3[1:0])
      2'b00: begin st_lane = {4{lsq_dc_wdata[7:0]}};  st_mk = 4'b0001 << lsq_dc_addr[1:0]; end
      2'b01: begin st_lane = {2{lsq_dc_wdata[15:0]}}; st_mk = lsq_dc_addr[1] ? 4'b1100 : 4'b0011; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (beat) begin
                  if (is_st) begin
                    if (ok) state_d = STORE;
                  end else if (ok && !hit) state_d = FILL_REQ;
                end
      STORE:    if (mem_ready) state_d = IDLE;
      FILL_REQ: if (mem_ready) state_d = FILL;
      FILL:     if (mem_rvalid && (&cnt_q)) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      lat_addr <= '0;
      lat_op   <= '0;
      lat_id   <= '0;
      st_wdata <= '0;
      st_mask  <= '0;
      hv_q     <= 1'b0;
      he_q     <= 1'b0;
      hd_q     <= '0;
      hid_q    <= '0;
    end else begin
      state_q <= state_d;
      hv_q    <= 1'b0;
      he_q    <= 1'b0;
      if (beat) begin
        lat_addr <= lsq_dc_addr;
        lat_op   <= f3;
        lat_id   <= lsq_dc_lsqid;
      end
      if (beat && !is_st && (!ok || hit)) begin
        hv_q  <= 1'b1;
        he_q  <= ~ok;
        hd_q  <= ok ? extract(data_q[idx][woff], f3, lsq_dc_addr[1:0]) : 32'd0;
        hid_q <= lsq_dc_lsqid;
      end
      if (beat && is_st && ok) begin
        st_wdata <= st_lane;
        st_mask  <= st_mk;
      end
      case (state_q)
        FILL_REQ: begin
          if (lsq_dc_flush) kill_q <= 1'b1;
          if (mem_ready) cnt_q <= '0;
        end
        FILL: begin
          if (lsq_dc_flush) kill_q <= 1'b1;
          if (mem_rvalid) begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) vld_q[lat_idx] <= 1'b1;
          end
        end
        RESP:    kill_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (beat && is_st && ok && hit) begin
      for (int b = 0; b < 4; b++)
        if (st_mk[b]) data_q[idx][woff][8*b +: 8] <= st_lane[8*b +: 8];
    end
    if (state_q == FILL && mem_rvalid) begin
      data_q[lat_idx][cnt_q] <= mem_rdata;
      if (&cnt_q) tag_q[lat_idx] <= lat_addr[31 -: TAG_W];
    end
  end

  assign resp_fill    = (state_q == RESP) & ~kill_q;
  assign dcache_ready = (state_q == IDLE) & ~rst;
  assign dcache_valid = (hv_q | resp_fill) & ~lsq_dc_flush;
  assign dcache_error = hv_q & he_q & ~lsq_dc_flush;
  assign dcache_lsqid = hv_q ? hid_q : (resp_fill ? lat_id : 4'd0);
  assign dcache_rdata = hv_q ? hd_q
                      : (resp_fill ? extract(data_q[lat_idx][lat_woff], lat_op, lat_addr[1:0]) : 32'd0);

  assign mem_req   = (state_q == STORE) | (state_q == FILL_REQ);
  assign mem_we    = (state_q == STORE);
  assign mem_addr  = (state_q == STORE)    ? {lat_addr[31:2], 2'b00}
                   : (state_q == FILL_REQ) ? {lat_addr[31:OFF_W], {OFF_W{1'b0}}} : 32'd0;
  assign mem_wdata = (state_q == STORE) ? st_wdata : 32'd0;
  assign mem_wmask = (state_q == STORE) ? st_mask : 4'd0;
endmodule

// File: tb/tb_dcache.sv
// Randomized and directed bench for dcache against a line-level reference model
// (reference memory image plus per-set valid/tag) and a bursting memory responder.
module tb_dcache;
  logic clk, rst;
  logic lsq_dc_req, lsq_dc_flush;
  logic [3:0] lsq_dc_op, lsq_dc_lsqid;
  logic [31:0] lsq_dc_addr, lsq_dc_wdata;
  logic dcache_ready, dcache_valid, dcache_error;
  logic [3:0] dcache_lsqid;
  logic [31:0] dcache_rdata;
  logic mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wmask;

  dcache #(.SETS(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op),
    .lsq_dc_addr(lsq_dc_addr), .lsq_dc_lsqid(lsq_dc_lsqid), .lsq_dc_wdata(lsq_dc_wdata),
    .lsq_dc_flush(lsq_dc_flush), .dcache_ready(dcache_ready), .dcache_valid(dcache_valid),
    .dcache_error(dcache_error), .dcache_lsqid(dcache_lsqid), .dcache_rdata(dcache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  initial clk = 0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tot = 0, pass = 0;

  typedef struct {int cyc; logic [3:0] id; logic [31:0] data; logic err;} resp_t;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] m;} wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  always @(negedge clk) if (dcache_valid) rq.push_back('{cyc, dcache_lsqid, dcache_rdata, dcache_error});

  // Backing memory (written only by the DUT) and reference image (written by the model).
  logic [31:0] mem [1024];
  logic [31:0] rmem [1024];
  int nrd = 0, nwr = 0, beat_i = 0, last_beat_cyc = 0;
  logic [31:0] last_rd = 0;
  bit fill_on = 0;
  logic [31:0] fill_base = 0;

  initial begin
    bit hs, hwe;
    logic [31:0] ha, hd;
    logic [3:0] hm;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      hs = mem_req && mem_ready && !rst; hwe = mem_we; ha = mem_addr; hd = mem_wdata; hm = mem_wmask;
      @(posedge clk); #1;
      mem_rvalid = 0;
      if (rst) fill_on = 0;
      if (hs && hwe) begin
        for (int b = 0; b < 4; b++) if (hm[b]) mem[ha[11:2]][8*b +: 8] = hd[8*b +: 8];
        wq.push_back('{ha, hd, hm}); nwr++;
      end else if (hs) begin
        fill_on = 1; fill_base = ha; beat_i = 0; nrd++; last_rd = ha;
      end else if (fill_on && !rst && $urandom_range(0, 3) != 0) begin
        mem_rvalid = 1; mem_rdata = mem[int'(fill_base[11:2]) + beat_i]; beat_i++;
        if (beat_i == 4) begin fill_on = 0; last_beat_cyc = cyc; end
      end
      mem_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Reference cache directory: which line each set holds.
  bit rv[64];
  int rt[64];

  function automatic logic [3:0] mkop(input int f3, input bit st);
    logic [2:0] f;
    f = f3[2:0];
    return {f, st};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int f3, input int a);
    logic [31:0] sh, b, h;
    sh = w >> (8 * (a % 4));
    b = sh & 32'hFF;
    h = sh & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return b;
      5: return h;
      default: return w;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [3:0] i,
                      input logic [31:0] w, output bit acc, output int acyc);
    int n;
    @(posedge clk); #1;
    lsq_dc_req = 1; lsq_dc_op = o; lsq_dc_addr = a; lsq_dc_lsqid = i; lsq_dc_wdata = w;
    n = 0;
    @(negedge clk);
    while (!dcache_ready && n < 300) begin @(negedge clk); n++; end
    acc = dcache_ready; acyc = cyc;
    @(posedge clk); #1;
    lsq_dc_req = 0;
  endtask

  task automatic wait_resp(output bit got, output resp_t r);
    int n;
    n = 0; got = 0; r = '{0, 4'd0, 32'd0, 1'b0};
    while (rq.size() == 0 && n < 300) begin @(negedge clk); #1; n++; end
    if (rq.size() > 0) begin got = 1; r = rq.pop_front(); end
  endtask

  task automatic wait_write(output bit got);
    int n;
    n = 0;
    while (wq.size() == 0 && n < 300) begin @(posedge clk); #2; n++; end
    got = (wq.size() > 0);
  endtask

  task automatic poll_beat(input int k, output bit seen);
    int n;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(posedge clk); #2;
      seen = mem_rvalid && (beat_i == k);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1; lsq_dc_req = 0; lsq_dc_op = 0; lsq_dc_addr = 0; lsq_dc_lsqid = 0;
    lsq_dc_wdata = 0; lsq_dc_flush = 0;
    @(negedge clk);
    tot++; if (dcache_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", dcache_valid); else pass++;
    tot++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b exp 0", mem_req); else pass++;
    tot++; if ({dcache_error, dcache_rdata, mem_wmask} !== 37'd0)
      $display("FAIL reset_outs: got %h exp 0", {dcache_error, dcache_rdata, mem_wmask}); else pass++;
    idle(2);
    rst = 0;
  endtask

  task automatic test_cold_miss();
    bit acc, got; int ac, r0; resp_t r;
    r0 = nrd;
    send(mkop(2, 0), 32'h100, 4'd3, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got) $display("FAIL cold_resp: got none exp response"); else pass++;
    tot++; if (r.data !== 32'h11 || r.id !== 4'd3 || r.err !== 1'b0)
      $display("FAIL cold_data: got %h/%h/%b exp 11/3/0", r.data, r.id, r.err); else pass++;
    tot++; if (nrd - r0 != 1 || last_rd !== 32'h100)
      $display("FAIL cold_memrd: got %0d reads @%h exp 1 @100", nrd - r0, last_rd); else pass++;
    tot++; if (r.cyc != last_beat_cyc + 1)
      $display("FAIL cold_latency: got cyc %0d exp %0d", r.cyc, last_beat_cyc + 1); else pass++;
    rv[16] = 1; rt[16] = 0;
    r0 = nrd;
    send(mkop(2, 0), 32'h104, 4'd5, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || r.data !== 32'h22 || r.id !== 4'd5)
      $display("FAIL hit_data: got %h/%h exp 22/5", r.data, r.id); else pass++;
    tot++; if (r.cyc != ac + 1 || nrd != r0)
      $display("FAIL hit_timing: got cyc %0d reads %0d exp %0d 0", r.cyc, nrd - r0, ac + 1); else pass++;
  endtask

  task automatic test_extract();
    bit acc, got; int ac; resp_t r;
    logic [31:0] exp_v [4];
    logic [31:0] adr [4];
    int fs [4];
    wq.delete();
    send(mkop(2, 1), 32'h100, 4'd0, 32'h80FF7F01, acc, ac);
    wait_write(got);
    rmem[32'h40] = 32'h80FF7F01;
    wq.delete();
    exp_v = '{32'hFFFFFF80, 32'h80, 32'hFFFF80FF, 32'h7F01};
    adr   = '{32'h103, 32'h103, 32'h102, 32'h100};
    fs    = '{0, 4, 1, 5};
    for (int k = 0; k < 4; k++) begin
      send(mkop(fs[k], 0), adr[k], 4'(k + 8), 0, acc, ac);
      wait_resp(got, r);
      tot++; if (!got || r.data !== exp_v[k])
        $display("FAIL extract_%0d: got %h exp %h", k, r.data, exp_v[k]); else pass++;
    end
  endtask

  task automatic test_store();
    bit acc, got; int ac; resp_t r;
    wq.delete(); rq.delete();
    send(mkop(0, 1), 32'h101, 4'd0, 32'hAB, acc, ac);
    @(negedge clk);
    tot++; if (dcache_ready !== 1'b0) $display("FAIL store_ready_low: got %b exp 0", dcache_ready); else pass++;
    wait_write(got);
    tot++; if (!got || wq[0].a !== 32'h100 || wq[0].d !== 32'hABABABAB || wq[0].m !== 4'b0010)
      $display("FAIL sb_write: got %h/%h/%b exp 100/ABABABAB/0010", wq[0].a, wq[0].d, wq[0].m); else pass++;
    @(negedge clk);
    tot++; if (dcache_ready !== 1'b1 || rq.size() != 0)
      $display("FAIL store_done: got ready %b resps %0d exp 1 0", dcache_ready, rq.size()); else pass++;
    rmem[32'h40] = 32'h80FFAB01;
    send(mkop(2, 0), 32'h100, 4'd6, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || r.data !== 32'h80FFAB01)
      $display("FAIL sb_merge: got %h exp 80FFAB01", r.data); else pass++;
  endtask

  task automatic test_errors();
    bit acc, got; int ac, r0, w0; resp_t r;
    r0 = nrd; w0 = nwr;
    send(mkop(2, 0), 32'h102, 4'd7, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || r.err !== 1'b1 || r.data !== 0 || r.id !== 4'd7 || r.cyc != ac + 1)
      $display("FAIL lw_misaligned: got %b/%h/%h cyc %0d exp 1/0/7 cyc %0d", r.err, r.data, r.id, r.cyc, ac + 1); else pass++;
    send(mkop(3, 0), 32'h100, 4'd2, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || r.err !== 1'b1) $display("FAIL ld_illegal: got %b exp 1", r.err); else pass++;
    send(mkop(1, 1), 32'h103, 4'd0, 32'h1234, acc, ac);
    @(negedge clk);
    tot++; if (dcache_ready !== 1'b1) $display("FAIL sh_misaligned_ready: got %b exp 1", dcache_ready); else pass++;
    idle(6);
    tot++; if (nrd != r0 || nwr != w0 || rq.size() != 0)
      $display("FAIL err_no_mem: got rd %0d wr %0d resp %0d exp 0 0 0", nrd - r0, nwr - w0, rq.size()); else pass++;
  endtask

  task automatic test_flush_fill();
    bit acc, got, seen; int ac, r0; resp_t r;
    rq.delete(); r0 = nrd;
    send(mkop(2, 0), 32'h200, 4'd9, 0, acc, ac);
    poll_beat(2, seen);
    lsq_dc_flush = 1;
    @(posedge clk); #1; lsq_dc_flush = 0;
    idle(20);
    tot++; if (!seen || rq.size() != 0 || nrd - r0 != 1)
      $display("FAIL flush_fill_quiet: got seen %b resps %0d reads %0d exp 1 0 1", seen, rq.size(), nrd - r0); else pass++;
    rv[32] = 1; rt[32] = 0;
    send(mkop(2, 0), 32'h204, 4'd10, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || r.data !== rmem[32'h81] || nrd - r0 != 1)
      $display("FAIL flush_fill_hit: got %h reads %0d exp %h 1", r.data, nrd - r0, rmem[32'h81]); else pass++;
  endtask

  task automatic test_flush_resp();
    bit acc, got, seen; int ac, r0; resp_t r;
    rq.delete(); r0 = nrd;
    send(mkop(2, 0), 32'h240, 4'd11, 0, acc, ac);
    poll_beat(4, seen);
    @(posedge clk); #1; lsq_dc_flush = 1;
    @(posedge clk); #1; lsq_dc_flush = 0;
    idle(4);
    tot++; if (!seen || rq.size() != 0) $display("FAIL flush_resp: got resps %0d exp 0", rq.size()); else pass++;
    rv[36] = 1; rt[36] = 0;
    send(mkop(2, 0), 32'h244, 4'd12, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || r.data !== rmem[32'h91] || nrd - r0 != 1)
      $display("FAIL flush_resp_hit: got %h reads %0d exp %h 1", r.data, nrd - r0, rmem[32'h91]); else pass++;
  endtask

  task automatic test_back_to_back();
    bit acc; int ac, r0;
    rq.delete(); r0 = nrd;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      lsq_dc_req = 1; lsq_dc_op = mkop(2, 0); lsq_dc_addr = 32'h100 + 32'(4 * (k - 1)); lsq_dc_lsqid = 4'(k);
      @(negedge clk);
      tot++; if (dcache_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b exp 1", k, dcache_ready); else pass++;
      @(posedge clk); #1;
    end
    lsq_dc_req = 0;
    idle(3);
    tot++; if (rq.size() != 3) $display("FAIL b2b_count: got %0d exp 3", rq.size()); else pass++;
    for (int k = 0; k < 3 && k < rq.size(); k++) begin
      tot++; if (rq[k].id !== 4'(k + 1) || rq[k].data !== rmem[32'h40 + k] || rq[k].cyc != rq[0].cyc + k)
        $display("FAIL b2b_resp_%0d: got %h/%h cyc %0d exp %h/%h cyc %0d", k, rq[k].id, rq[k].data,
                 rq[k].cyc, k + 1, rmem[32'h40 + k], rq[0].cyc + k); else pass++;
    end
    rq.delete();
    @(posedge clk); #1;
    lsq_dc_req = 1; lsq_dc_flush = 1; lsq_dc_addr = 32'h100; lsq_dc_lsqid = 4'd13;
    @(posedge clk); #1;
    lsq_dc_req = 0; lsq_dc_flush = 0;
    send(mkop(2, 0), 32'h104, 4'd14, 0, acc, ac);
    lsq_dc_flush = 1;
    @(posedge clk); #1; lsq_dc_flush = 0;
    idle(4);
    tot++; if (rq.size() != 0 || nrd != r0)
      $display("FAIL flush_req: got resps %0d reads %0d exp 0 0", rq.size(), nrd - r0); else pass++;
  endtask

  task automatic test_reset_midfill();
    bit acc, got, seen; int ac, r0; resp_t r;
    rq.delete();
    send(mkop(2, 0), 32'h300, 4'd4, 0, acc, ac);
    poll_beat(2, seen);
    rst = 1;
    @(posedge clk); #2; rst = 0;
    for (int s = 0; s < 64; s++) rv[s] = 0;
    idle(8);
    tot++; if (!seen || rq.size() != 0 || mem_req !== 1'b0)
      $display("FAIL rst_midfill_quiet: got resps %0d mem_req %b exp 0 0", rq.size(), mem_req); else pass++;
    r0 = nrd;
    send(mkop(2, 0), 32'h104, 4'd1, 0, acc, ac);
    wait_resp(got, r);
    tot++; if (!got || nrd - r0 != 1 || r.data !== rmem[32'h41])
      $display("FAIL rst_midfill_refill: got %h reads %0d exp %h 1", r.data, nrd - r0, rmem[32'h41]); else pass++;
    rv[16] = 1; rt[16] = 0;
  endtask

  task automatic test_random();
    bit acc, got, st, ok, hit; int ac, r0, f3, sz, a, s, tg, nb; resp_t r;
    logic [31:0] wd, ed; logic [3:0] em, id;
    for (int it = 0; it < 150; it++) begin
      tg = $urandom_range(0, 3); s = $urandom_range(0, 3);
      f3 = $urandom_range(0, 7); st = ($urandom_range(0, 2) == 0);
      sz = f3 % 4;
      a = tg * 1024 + s * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0 && sz < 3) a = a - (a % (1 << sz));
      ok = (st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5)) && (a % (1 << (sz % 3))) == 0;
      hit = rv[s] && rt[s] == tg;
      wd = $urandom; id = 4'($urandom_range(0, 15));
      rq.delete(); wq.delete(); r0 = nrd;
      send(mkop(f3, st), 32'(a), id, wd, acc, ac);
      if (!st) begin
        wait_resp(got, r);
        ed = ok ? ref_load(rmem[a / 4], f3, a) : 32'd0;
        tot++; if (!got || r.id !== id || r.err !== !ok || r.data !== ed)
          $display("FAIL rnd_load_%0d: got %h/%b/%h exp %h/%b/%h (op %0d a %h)", it, r.id, r.err, r.data,
                   id, !ok, ed, f3, a); else pass++;
        tot++; if (nrd - r0 != ((ok && !hit) ? 1 : 0))
          $display("FAIL rnd_reads_%0d: got %0d exp %0d", it, nrd - r0, (ok && !hit) ? 1 : 0); else pass++;
        if (ok && !hit) begin rv[s] = 1; rt[s] = tg; end
      end else if (ok) begin
        nb = 1 << sz;
        for (int b = 0; b < 4; b++) ed[8*b +: 8] = wd[8*(b % nb) +: 8];
        em = 4'(((1 << nb) - 1) << (a % 4));
        wait_write(got);
        tot++; if (!got || wq[0].a !== 32'(a - a % 4) || wq[0].d !== ed || wq[0].m !== em)
          $display("FAIL rnd_store_%0d: got %h/%h/%b exp %h/%h/%b", it, wq[0].a, wq[0].d, wq[0].m,
                   a - a % 4, ed, em); else pass++;
        for (int b = 0; b < 4; b++) if (em[b]) rmem[a / 4][8*b +: 8] = ed[8*b +: 8];
        idle(2);
        tot++; if (rq.size() != 0) $display("FAIL rnd_store_resp_%0d: got %0d exp 0", it, rq.size()); else pass++;
      end else begin
        idle(4);
        tot++; if (wq.size() != 0 || rq.size() != 0)
          $display("FAIL rnd_bad_store_%0d: got wr %0d resp %0d exp 0 0", it, wq.size(), rq.size()); else pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; rmem[i] = mem[i]; end
    for (int i = 0; i < 4; i++) begin mem[32'h40 + i] = 32'(17 * (i + 1)); rmem[32'h40 + i] = mem[32'h40 + i]; end
    for (int s = 0; s < 64; s++) begin rv[s] = 0; rt[s] = 0; end
    test_reset();
    test_cold_miss();
    test_extract();
    test_store();
    test_errors();
    test_flush_fill();
    test_flush_resp();
    test_back_to_back();
    test_reset_midfill();
    test_random();
    idle(3);
    tot++; if (rq.size() != 0) $display("FAIL stray_resp: got %0d exp 0", rq.size()); else pass++;
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end
endmodule
